// File: rtl/xbus_seq.sv
// xbus_seq: bus-cycle sequencer for the multiplexed 8-bit RAM bus.
// Turns a single-cycle CPU request into address-low, optional address-high and data
// phases, and returns read data with a one-cycle ack. The address-high phase is skipped
// when the RAM is known to already hold the same high byte.
//
// Ports:
//   wb_clk_i, rst          clock, synchronous active-high reset
//   req, req_we, req_addr, req_wdata
//                          request pulse and its payload, sampled only while idle
//   busy, ack, rdata       access in progress, completion pulse, read data
//   ram_enabled            RAM enable; when low the RAM zeroes its address
//   bus_out, bus_oe, bus_in
//                          memory bus byte out, drive enable, byte in
//   le_lo_act, le_hi_act   address-low / address-high latch strobes
//   WEb_raw                active-low write strobe
module xbus_seq #(
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        wb_clk_i,
    input  logic        rst,
    input  logic        req,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        busy,
    output logic        ack,
    output logic [7:0]  rdata,
    input  logic        ram_enabled,
    output logic [7:0]  bus_out,
    output logic        bus_oe,
    input  logic [7:0]  bus_in,
    output logic        le_lo_act,
    output logic        le_hi_act,
    output logic        WEb_raw
);

    localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        StIdle,
        StAlo,
        StAhi,
        StData
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  hi_last_q, hi_last_d;
    logic        hi_valid_q, hi_valid_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        ack_q, ack_d;
    logic        busy_q, busy_d;
    logic [7:0]  bus_out_q, bus_out_d;
    logic        bus_oe_q, bus_oe_d;
    logic        le_lo_q, le_lo_d;
    logic        le_hi_q, le_hi_d;
    logic        web_q, web_d;

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        hi_last_d  = hi_last_q;
        hi_valid_d = hi_valid_q;
        rdata_d    = rdata_q;
        ack_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    addr_d  = req_addr;
                    we_d    = req_we;
                    wdata_d = req_wdata;
                    state_d = StAlo;
                end
            end
            StAlo: begin
                if (hi_valid_q && (hi_last_q == addr_q[15:8])) begin
                    state_d = StData;
                    cnt_d   = WaitLoad;
                end else begin
                    state_d = StAhi;
                end
            end
            StAhi: begin
                hi_last_d  = addr_q[15:8];
                hi_valid_d = 1'b1;
                state_d    = StData;
                cnt_d      = WaitLoad;
            end
            StData: begin
                if (cnt_q == 4'd0) begin
                    state_d = StIdle;
                    ack_d   = 1'b1;
                    if (!we_q) begin
                        rdata_d = ram_enabled ? bus_in : 8'h00;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
        endcase

        // A disabled RAM zeroes its address, so the remembered high byte is stale.
        if (!ram_enabled) begin
            hi_valid_d = 1'b0;
        end
    end

    // Registered bus-side outputs, decoded from the state being entered.
    always_comb begin
        busy_d    = (state_d != StIdle);
        bus_out_d = 8'h00;
        bus_oe_d  = 1'b0;
        le_lo_d   = 1'b0;
        le_hi_d   = 1'b0;
        web_d     = 1'b1;

        unique case (state_d)
            StIdle: begin
            end
            StAlo: begin
                bus_out_d = addr_d[7:0];
                bus_oe_d  = 1'b1;
                le_lo_d   = 1'b1;
            end
            StAhi: begin
                bus_out_d = addr_d[15:8];
                bus_oe_d  = 1'b1;
                le_hi_d   = 1'b1;
            end
            StData: begin
                if (we_d) begin
                    bus_out_d = wdata_d;
                    bus_oe_d  = 1'b1;
                    web_d     = ~ram_enabled;
                end
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= 16'h0000;
            we_q       <= 1'b0;
            wdata_q    <= 8'h00;
            cnt_q      <= 4'd0;
            hi_last_q  <= 8'h00;
            hi_valid_q <= 1'b0;
            rdata_q    <= 8'h00;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            bus_out_q  <= 8'h00;
            bus_oe_q   <= 1'b0;
            le_lo_q    <= 1'b0;
            le_hi_q    <= 1'b0;
            web_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            hi_last_q  <= hi_last_d;
            hi_valid_q <= hi_valid_d;
            rdata_q    <= rdata_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            bus_out_q  <= bus_out_d;
            bus_oe_q   <= bus_oe_d;
            le_lo_q    <= le_lo_d;
            le_hi_q    <= le_hi_d;
            web_q      <= web_d;
        end
    end

    assign busy      = busy_q;
    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign bus_out   = bus_out_q;
    assign bus_oe    = bus_oe_q;
    assign le_lo_act = le_lo_q;
    assign le_hi_act = le_hi_q;
    assign WEb_raw   = web_q;

endmodule

// File: tb/tb_xbus_seq.sv
// Bench for xbus_seq: one instance with no wait states attached to a behavioural RAM,
// and one instance with three wait states whose bus_in is a fixed byte.
module tb_xbus_seq;

    logic        clk = 1'b0;
    logic        rst, req, req_we, en;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    bit          sel;

    logic        busy0, ack0, oe0, lo0, hi0, web0;
    logic [7:0]  rdata0, bus0, bus_in0;
    logic        busy3, ack3, oe3, lo3, hi3, web3;
    logic [7:0]  rdata3, bus3;
    logic        req0, req3;

    int nvec, nerr;

    always #5 clk = ~clk;

    assign req0 = req & ~sel;
    assign req3 = req & sel;

    xbus_seq #(.WAIT_CYCLES(0)) u_dut0 (
        .wb_clk_i(clk), .rst(rst), .req(req0), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .busy(busy0), .ack(ack0), .rdata(rdata0),
        .ram_enabled(en), .bus_out(bus0), .bus_oe(oe0), .bus_in(bus_in0),
        .le_lo_act(lo0), .le_hi_act(hi0), .WEb_raw(web0)
    );

    xbus_seq #(.WAIT_CYCLES(3)) u_dut3 (
        .wb_clk_i(clk), .rst(rst), .req(req3), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .busy(busy3), .ack(ack3), .rdata(rdata3),
        .ram_enabled(en), .bus_out(bus3), .bus_oe(oe3), .bus_in(8'h3C),
        .le_lo_act(lo3), .le_hi_act(hi3), .WEb_raw(web3)
    );

    // Observation of whichever instance is selected.
    logic       o_busy, o_ack, o_oe, o_lo, o_hi, o_web;
    logic [7:0] o_rdata, o_bus;
    assign o_busy  = sel ? busy3 : busy0;
    assign o_ack   = sel ? ack3 : ack0;
    assign o_oe    = sel ? oe3 : oe0;
    assign o_lo    = sel ? lo3 : lo0;
    assign o_hi    = sel ? hi3 : hi0;
    assign o_web   = sel ? web3 : web0;
    assign o_rdata = sel ? rdata3 : rdata0;
    assign o_bus   = sel ? bus3 : bus0;

    // Initial RAM contents before any write.
    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Behavioural RAM: latches address bytes on strobes, writes when WEb is low,
    // zeroes its address while disabled.
    logic [7:0] ram_alo, ram_ahi;
    logic [7:0] ram_mem [0:65535];
    bit         ram_wr  [0:65535];
    assign bus_in0 = ram_wr[{ram_ahi, ram_alo}] ? ram_mem[{ram_ahi, ram_alo}]
                                                : pat({ram_ahi, ram_alo});
    always @(posedge clk) begin
        if (!en) begin
            ram_alo <= 8'h00;
            ram_ahi <= 8'h00;
        end else begin
            if (lo0) ram_alo <= bus0;
            if (hi0) ram_ahi <= bus0;
            if (!web0) begin
                ram_mem[{ram_ahi, ram_alo}] <= bus0;
                ram_wr[{ram_ahi, ram_alo}]  <= 1'b1;
            end
        end
    end

    // Reference model state: per instance, whether the RAM's high byte is known,
    // its value, and the last returned read byte; plus the memory image.
    bit         m_hv [2];
    logic [7:0] m_hl [2];
    logic [7:0] m_rd [2];
    logic [7:0] model_mem [int];

    function automatic logic [7:0] mem_rd(input logic [15:0] a);
        return model_mem.exists(int'(a)) ? model_mem[int'(a)] : pat(a);
    endfunction

    // en is held constant for the whole access.
    task automatic model_access(input int s, input bit we, input logic [15:0] a,
                                input logic [7:0] wd, output int lat, output int nhi,
                                output int nweb);
        bit skip;
        int wait_c;
        wait_c = (s == 1) ? 3 : 0;
        if (!en) begin
            m_hv[0] = 1'b0;
            m_hv[1] = 1'b0;
        end
        skip = m_hv[s] && (m_hl[s] == a[15:8]);
        if (!skip) begin
            m_hl[s] = a[15:8];
            m_hv[s] = en;
        end
        lat  = (skip ? 3 : 4) + wait_c;
        nhi  = skip ? 0 : 1;
        nweb = (we && en) ? wait_c + 1 : 0;
        if (we && en && s == 0) model_mem[int'(a)] = wd;
        if (!we) m_rd[s] = !en ? 8'h00 : ((s == 1) ? 8'h3C : mem_rd(a));
    endtask

    task automatic model_clear(input bit by_reset);
        for (int i = 0; i < 2; i++) begin
            m_hv[i] = 1'b0;
            if (by_reset) m_rd[i] = 8'h00;
        end
    endtask

    // Issues one request at the current negedge and observes until ack (bounded).
    // Returns at the negedge of the ack cycle so a following call is back-to-back.
    task automatic run_access(input bit we, input logic [15:0] a, input logic [7:0] wd,
                              output int lat, output int nlo, output int nhi,
                              output int nweb, output logic [7:0] lo_b,
                              output logic [7:0] hi_b, output logic [7:0] wd_b,
                              output int bad);
        lat = -1; nlo = 0; nhi = 0; nweb = 0; bad = 0;
        lo_b = 8'h00; hi_b = 8'h00; wd_b = 8'h00;
        req = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            req = 1'b0;
            if (o_lo) begin nlo++; lo_b = o_bus; if (c != 1) bad++; end
            if (o_hi) begin nhi++; hi_b = o_bus; if (c != 2) bad++; end
            if (!o_web) begin nweb++; wd_b = o_bus; end
            if (int'(o_lo) + int'(o_hi) + int'(!o_web) > 1) bad++;
            if (!o_oe && o_bus !== 8'h00) bad++;
            if (!we && c >= 2 && o_oe && !o_hi) bad++;
            if (o_ack) begin
                if (o_busy) bad++;
                lat = c;
                break;
            end
            if (!o_busy) bad++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; req = 1'b0; sel = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        model_clear(1'b1);
        nvec++; if (busy0 !== 1'b0) begin nerr++; $display("FAIL rst_busy got %b want 0", busy0); end
        nvec++; if (ack0 !== 1'b0) begin nerr++; $display("FAIL rst_ack got %b want 0", ack0); end
        nvec++; if (rdata0 !== 8'h00) begin nerr++; $display("FAIL rst_rdata got %h want 00", rdata0); end
        nvec++; if (bus0 !== 8'h00) begin nerr++; $display("FAIL rst_bus got %h want 00", bus0); end
        nvec++; if (oe0 !== 1'b0) begin nerr++; $display("FAIL rst_oe got %b want 0", oe0); end
        nvec++; if (lo0 !== 1'b0 || hi0 !== 1'b0) begin
            nerr++; $display("FAIL rst_le got %b%b want 00", lo0, hi0); end
        nvec++; if (web0 !== 1'b1) begin nerr++; $display("FAIL rst_web got %b want 1", web0); end
        nvec++; if ({busy3, ack3, rdata3, bus3, oe3, lo3, hi3, web3} !== 22'h000001) begin
            nerr++; $display("FAIL rst_dut3 got %h want 000001",
                             {busy3, ack3, rdata3, bus3, oe3, lo3, hi3, web3}); end
    endtask

    task automatic test_write_full();
        int lat, nlo, nhi, nweb, bad, el, eh, ew;
        logic [7:0] lo_b, hi_b, wd_b;
        sel = 1'b0;
        model_access(0, 1'b1, 16'h0123, 8'hA5, el, eh, ew);
        run_access(1'b1, 16'h0123, 8'hA5, lat, nlo, nhi, nweb, lo_b, hi_b, wd_b, bad);
        nvec++; if (lat !== 4) begin nerr++; $display("FAIL wr_lat got %0d want 4", lat); end
        nvec++; if (nlo !== 1 || lo_b !== 8'h23) begin
            nerr++; $display("FAIL wr_alo got %0d/%h want 1/23", nlo, lo_b); end
        nvec++; if (nhi !== 1 || hi_b !== 8'h01) begin
            nerr++; $display("FAIL wr_ahi got %0d/%h want 1/01", nhi, hi_b); end
        nvec++; if (nweb !== 1 || wd_b !== 8'hA5) begin
            nerr++; $display("FAIL wr_data got %0d/%h want 1/a5", nweb, wd_b); end
        nvec++; if (bad !== 0) begin nerr++; $display("FAIL wr_proto got %0d want 0", bad); end
        nvec++; if (ram_mem[16'h0123] !== 8'hA5) begin
            nerr++; $display("FAIL wr_ram got %h want a5", ram_mem[16'h0123]); end
    endtask

    task automatic test_read_skip();
        int lat, nlo, nhi, nweb, bad, el, eh, ew;
        logic [7:0] lo_b, hi_b, wd_b;
        model_access(0, 1'b0, 16'h0123, 8'h00, el, eh, ew);
        run_access(1'b0, 16'h0123, 8'h00, lat, nlo, nhi, nweb, lo_b, hi_b, wd_b, bad);
        nvec++; if (lat !== 3) begin nerr++; $display("FAIL rds_lat got %0d want 3", lat); end
        nvec++; if (nhi !== 0) begin nerr++; $display("FAIL rds_ahi got %0d want 0", nhi); end
        nvec++; if (rdata0 !== 8'hA5) begin nerr++; $display("FAIL rds_rdata got %h want a5", rdata0); end
        nvec++; if (bad !== 0 || nweb !== 0) begin
            nerr++; $display("FAIL rds_proto got %0d/%0d want 0/0", bad, nweb); end
    endtask

    task automatic test_read_newhi();
        int lat, nlo, nhi, nweb, bad, el, eh, ew;
        logic [7:0] lo_b, hi_b, wd_b;
        model_access(0, 1'b0, 16'h0200, 8'h00, el, eh, ew);
        run_access(1'b0, 16'h0200, 8'h00, lat, nlo, nhi, nweb, lo_b, hi_b, wd_b, bad);
        nvec++; if (lat !== 4) begin nerr++; $display("FAIL rdh_lat got %0d want 4", lat); end
        nvec++; if (nhi !== 1 || hi_b !== 8'h02) begin
            nerr++; $display("FAIL rdh_ahi got %0d/%h want 1/02", nhi, hi_b); end
        nvec++; if (rdata0 !== m_rd[0]) begin
            nerr++; $display("FAIL rdh_rdata got %h want %h", rdata0, m_rd[0]); end
    endtask

    task automatic test_wait();
        int lat, nlo, nhi, nweb, bad, el, eh, ew;
        logic [7:0] lo_b, hi_b, wd_b;
        sel = 1'b1;
        model_access(1, 1'b1, 16'h0123, 8'h77, el, eh, ew);
        run_access(1'b1, 16'h0123, 8'h77, lat, nlo, nhi, nweb, lo_b, hi_b, wd_b, bad);
        nvec++; if (lat !== 7) begin nerr++; $display("FAIL wt_lat got %0d want 7", lat); end
        nvec++; if (nweb !== 4 || wd_b !== 8'h77) begin
            nerr++; $display("FAIL wt_web got %0d/%h want 4/77", nweb, wd_b); end
        nvec++; if (bad !== 0) begin nerr++; $display("FAIL wt_proto got %0d want 0", bad); end
        model_access(1, 1'b0, 16'h0150, 8'h00, el, eh, ew);
        run_access(1'b0, 16'h0150, 8'h00, lat, nlo, nhi, nweb, lo_b, hi_b, wd_b, bad);
        nvec++; if (lat !== 6) begin nerr++; $display("FAIL wt_rdlat got %0d want 6", lat); end
        nvec++; if (rdata3 !== 8'h3C) begin nerr++; $display("FAIL wt_rdata got %h want 3c", rdata3); end
        sel = 1'b0;
    endtask

    task automatic test_ram_toggle();
        int lat, nlo, nhi, nweb, bad, el, eh, ew;
        logic [7:0] lo_b, hi_b, wd_b;
        model_access(0, 1'b0, 16'h0100, 8'h00, el, eh, ew);
        run_access(1'b0, 16'h0100, 8'h00, lat, nlo, nhi, nweb, lo_b, hi_b, wd_b, bad);
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        model_clear(1'b0);
        model_access(0, 1'b1, 16'h0123, 8'h5A, el, eh, ew);
        run_access(1'b1, 16'h0123, 8'h5A, lat, nlo, nhi, nweb, lo_b, hi_b, wd_b, bad);
        nvec++; if (nhi !== 1 || hi_b !== 8'h01) begin
            nerr++; $display("FAIL tog_ahi got %0d/%h want 1/01", nhi, hi_b); end
        nvec++; if (lat !== 4) begin nerr++; $display("FAIL tog_lat got %0d want 4", lat); end
        nvec++; if (ram_mem[16'h0123] !== 8'h5A) begin
            nerr++; $display("FAIL tog_ram got %h want 5a", ram_mem[16'h0123]); end
    endtask

    task automatic test_ram_off();
        int lat, nlo, nhi, nweb, bad, el, eh, ew;
        logic [7:0] lo_b, hi_b, wd_b;
        en = 1'b0;
        model_access(0, 1'b1, 16'h0130, 8'h99, el, eh, ew);
        run_access(1'b1, 16'h0130, 8'h99, lat, nlo, nhi, nweb, lo_b, hi_b, wd_b, bad);
        nvec++; if (nweb !== 0) begin nerr++; $display("FAIL off_web got %0d want 0", nweb); end
        nvec++; if (lat !== 4) begin nerr++; $display("FAIL off_wlat got %0d want 4", lat); end
        nvec++; if (ram_wr[16'h0130] !== 1'b0) begin
            nerr++; $display("FAIL off_ram got %b want 0", ram_wr[16'h0130]); end
        model_access(0, 1'b0, 16'h0123, 8'h00, el, eh, ew);
        run_access(1'b0, 16'h0123, 8'h00, lat, nlo, nhi, nweb, lo_b, hi_b, wd_b, bad);
        nvec++; if (rdata0 !== 8'h00) begin nerr++; $display("FAIL off_rdata got %h want 00", rdata0); end
        nvec++; if (lat !== 4) begin nerr++; $display("FAIL off_rlat got %0d want 4", lat); end
        en = 1'b1;
    endtask

    task automatic test_back_to_back();
        int lat, nlo, nhi, nweb, bad, el, eh, ew;
        logic [7:0] lo_b, hi_b, wd_b;
        model_access(0, 1'b1, 16'h0300, 8'hC3, el, eh, ew);
        run_access(1'b1, 16'h0300, 8'hC3, lat, nlo, nhi, nweb, lo_b, hi_b, wd_b, bad);
        nvec++; if (lat !== 4) begin nerr++; $display("FAIL b2b_wlat got %0d want 4", lat); end
        model_access(0, 1'b0, 16'h0300, 8'h00, el, eh, ew);
        run_access(1'b0, 16'h0300, 8'h00, lat, nlo, nhi, nweb, lo_b, hi_b, wd_b, bad);
        nvec++; if (lat !== 3) begin nerr++; $display("FAIL b2b_rlat got %0d want 3", lat); end
        nvec++; if (rdata0 !== 8'hC3) begin nerr++; $display("FAIL b2b_rdata got %h want c3", rdata0); end
    endtask

    task automatic test_reset_mid();
        int lat, nlo, nhi, nweb, bad, el, eh, ew;
        logic [7:0] lo_b, hi_b, wd_b;
        sel = 1'b1;
        req = 1'b1; req_we = 1'b1; req_addr = 16'h7700; req_wdata = 8'h11;
        @(negedge clk);
        req = 1'b0;
        repeat (2) @(negedge clk);
        nvec++; if (web3 !== 1'b0) begin nerr++; $display("FAIL mid_data got %b want 0", web3); end
        rst = 1'b1;
        @(negedge clk);
        nvec++; if ({web3, busy3, ack3} !== 3'b100) begin
            nerr++; $display("FAIL mid_abort got %b want 100", {web3, busy3, ack3}); end
        rst = 1'b0;
        model_clear(1'b1);
        model_access(1, 1'b0, 16'h7700, 8'h00, el, eh, ew);
        run_access(1'b0, 16'h7700, 8'h00, lat, nlo, nhi, nweb, lo_b, hi_b, wd_b, bad);
        nvec++; if (nhi !== 1 || hi_b !== 8'h77) begin
            nerr++; $display("FAIL mid_ahi got %0d/%h want 1/77", nhi, hi_b); end
        nvec++; if (lat !== 7) begin nerr++; $display("FAIL mid_lat got %0d want 7", lat); end
        sel = 1'b0;
    endtask

    task automatic test_random();
        int lat, nlo, nhi, nweb, bad, el, eh, ew;
        logic [7:0] lo_b, hi_b, wd_b, wd;
        logic [15:0] a;
        bit we;
        sel = 1'b0;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            en = ($urandom_range(0, 7) != 0);
            a  = {8'($urandom_range(1, 3)), 8'($urandom)};
            we = 1'($urandom);
            wd = 8'($urandom);
            model_access(0, we, a, wd, el, eh, ew);
            run_access(we, a, wd, lat, nlo, nhi, nweb, lo_b, hi_b, wd_b, bad);
            nvec++; if (lat !== el) begin
                nerr++; $display("FAIL rnd%0d_lat got %0d want %0d", i, lat, el); end
            nvec++; if (nlo !== 1 || lo_b !== a[7:0] || nhi !== eh) begin
                nerr++; $display("FAIL rnd%0d_addr got %0d/%h/%0d want 1/%h/%0d",
                                 i, nlo, lo_b, nhi, a[7:0], eh); end
            nvec++; if (nweb !== ew || (ew != 0 && wd_b !== wd)) begin
                nerr++; $display("FAIL rnd%0d_web got %0d/%h want %0d/%h", i, nweb, wd_b, ew, wd); end
            nvec++; if (rdata0 !== m_rd[0]) begin
                nerr++; $display("FAIL rnd%0d_rdata got %h want %h", i, rdata0, m_rd[0]); end
            nvec++; if (bad !== 0) begin nerr++; $display("FAIL rnd%0d_proto got %0d want 0", i, bad); end
            en = 1'b1;
        end
    endtask

    initial begin
        nvec = 0; nerr = 0;
        sel = 1'b0; req = 1'b0; req_we = 1'b0; req_addr = 16'h0000; req_wdata = 8'h00;
        en = 1'b0; rst = 1'b1;
        test_reset();
        test_write_full();
        test_read_skip();
        test_read_newhi();
        test_wait();
        test_ram_toggle();
        test_ram_off();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
